// File: rtl/fetch_decode_control_pkg.sv
// Shared widths, the F/D register layout and the hazard-priority encoding for
// the fetch/decode boundary.
package fetch_decode_control_pkg;

  localparam int INSTR_W = 22;
  localparam int REG_W   = 4;

  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [INSTR_W-1:0] pc;
    logic               valid;
  } fd_reg_t;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_BRANCH,
    SEL_PC_SRC,
    SEL_PC_PENDING,
    SEL_LOAD_USE
  } hazard_sel_t;

  function automatic fd_reg_t nop_fd();
    fd_reg_t r;
    r.instr = NOP_INSTR;
    r.pc    = '0;
    r.valid = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/fetch_decode_control_hazard_detect.sv
// Combinational hazard resolution: picks exactly one of branch, W-stage PC
// write, pending PC write, load-use or normal flow, and derives stall/flush.
module hazard_detect
  import fetch_decode_control_pkg::*;
(
  input  logic             valid_d,
  input  logic             pc_write_d,
  input  logic [REG_W-1:0] rn_d,
  input  logic [REG_W-1:0] rm_d,
  input  logic [REG_W-1:0] rd_e,
  input  logic             mem_to_reg_e,
  input  logic             branch_taken_e,
  input  logic             pc_src_w,
  input  logic             pcw_e,
  input  logic             pcw_m,
  output logic             stall_f,
  output logic             flush_e,
  output hazard_sel_t      sel
);

  logic load_use;
  logic pc_pending;

  assign load_use   = mem_to_reg_e & valid_d & ((rd_e == rn_d) | (rd_e == rm_d));
  assign pc_pending = (valid_d & pc_write_d) | pcw_e | pcw_m;

  always_comb begin
    sel     = SEL_NONE;
    stall_f = 1'b0;
    flush_e = 1'b0;
    if (branch_taken_e) begin
      sel     = SEL_BRANCH;
      flush_e = 1'b1;
    end else if (pc_src_w) begin
      sel = SEL_PC_SRC;
    end else if (pc_pending) begin
      sel = SEL_PC_PENDING;
    end else if (load_use) begin
      sel     = SEL_LOAD_USE;
      stall_f = 1'b1;
      flush_e = 1'b1;
    end
  end

endmodule

// File: rtl/fetch_decode_control.sv
// Consumer end of the fetch interface: F/D pipeline register, PC-write
// tracking, fetch stall / execute flush generation and a bubble counter.
module fetch_decode_control
  import fetch_decode_control_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instruction_fetch_in,
  input  logic [INSTR_W-1:0] pc_plus_8_in,
  input  logic               pc_write_d,
  input  logic [REG_W-1:0]   rn_d,
  input  logic [REG_W-1:0]   rm_d,
  input  logic [REG_W-1:0]   rd_e,
  input  logic               mem_to_reg_e,
  input  logic               branch_taken_e,
  input  logic               pc_src_w,
  output logic [INSTR_W-1:0] instruction_decode_out,
  output logic [INSTR_W-1:0] pc_plus_8_decode_out,
  output logic               valid_decode_out,
  output logic               stall_fetch_out,
  output logic               flush_execute_out,
  output logic [CNT_W-1:0]   bubble_count_out
);

  fd_reg_t     fd_q;
  fd_reg_t     fd_next;
  logic        fd_en;
  logic        pcw_e;
  logic        pcw_m;
  logic        stall_f;
  logic        flush_e;
  hazard_sel_t sel;
  logic [CNT_W-1:0] bubble_q;

  hazard_detect u_hazard (
    .valid_d        (fd_q.valid),
    .pc_write_d     (pc_write_d),
    .rn_d           (rn_d),
    .rm_d           (rm_d),
    .rd_e           (rd_e),
    .mem_to_reg_e   (mem_to_reg_e),
    .branch_taken_e (branch_taken_e),
    .pc_src_w       (pc_src_w),
    .pcw_e          (pcw_e),
    .pcw_m          (pcw_m),
    .stall_f        (stall_f),
    .flush_e        (flush_e),
    .sel            (sel)
  );

  // Every hazard case except load-use discards the fetched word; load-use holds D.
  always_comb begin
    fd_en   = (sel != SEL_LOAD_USE);
    fd_next = nop_fd();
    if (sel == SEL_NONE) begin
      fd_next.instr = instruction_fetch_in;
      fd_next.pc    = pc_plus_8_in;
      fd_next.valid = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fd_q <= '0;
    end else if (fd_en) begin
      fd_q <= fd_next;
    end
  end

  // The W stage of a PC write is announced by pc_src_w itself, so tracking stops at M.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcw_e <= 1'b0;
      pcw_m <= 1'b0;
    end else begin
      pcw_e <= fd_q.valid & pc_write_d & ~flush_e & ~branch_taken_e;
      pcw_m <= pcw_e;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_q <= '0;
    end else if ((sel != SEL_NONE) && (bubble_q != {CNT_W{1'b1}})) begin
      bubble_q <= bubble_q + CNT_W'(1);
    end
  end

  assign instruction_decode_out = fd_q.instr;
  assign pc_plus_8_decode_out   = fd_q.pc;
  assign valid_decode_out       = fd_q.valid;
  assign stall_fetch_out        = stall_f;
  assign flush_execute_out      = flush_e;
  assign bubble_count_out       = bubble_q;

endmodule

// File: tb/tb_fetch_decode_control.sv
// Directed bench for fetch_decode_control: reset, load-use, branch, PC write,
// simultaneous hazards and bubble-counter saturation (CNT_W = 4).
module tb_fetch_decode_control;
  import fetch_decode_control_pkg::*;

  localparam int CW = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [INSTR_W-1:0] instruction_fetch_in;
  logic [INSTR_W-1:0] pc_plus_8_in;
  logic               pc_write_d;
  logic [REG_W-1:0]   rn_d, rm_d, rd_e;
  logic               mem_to_reg_e, branch_taken_e, pc_src_w;
  logic [INSTR_W-1:0] instruction_decode_out, pc_plus_8_decode_out;
  logic               valid_decode_out, stall_fetch_out, flush_execute_out;
  logic [CW-1:0]      bubble_count_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_decode_control #(.CNT_W(CW)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .instruction_fetch_in   (instruction_fetch_in),
    .pc_plus_8_in           (pc_plus_8_in),
    .pc_write_d             (pc_write_d),
    .rn_d                   (rn_d),
    .rm_d                   (rm_d),
    .rd_e                   (rd_e),
    .mem_to_reg_e           (mem_to_reg_e),
    .branch_taken_e         (branch_taken_e),
    .pc_src_w               (pc_src_w),
    .instruction_decode_out (instruction_decode_out),
    .pc_plus_8_decode_out   (pc_plus_8_decode_out),
    .valid_decode_out       (valid_decode_out),
    .stall_fetch_out        (stall_fetch_out),
    .flush_execute_out      (flush_execute_out),
    .bubble_count_out       (bubble_count_out)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [INSTR_W-1:0] instr, input logic [INSTR_W-1:0] pc,
                               input logic pcw, input logic [REG_W-1:0] rn, input logic [REG_W-1:0] rm,
                               input logic [REG_W-1:0] rd, input logic mtr, input logic br,
                               input logic psrc);
    instruction_fetch_in = instr;
    pc_plus_8_in         = pc;
    pc_write_d           = pcw;
    rn_d                 = rn;
    rm_d                 = rm;
    rd_e                 = rd;
    mem_to_reg_e         = mtr;
    branch_taken_e       = br;
    pc_src_w             = psrc;
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkD(input string tag, input logic [INSTR_W-1:0] instr,
                        input logic [INSTR_W-1:0] pc, input logic valid);
    checkOutput({tag, ".instr"}, 32'(instruction_decode_out), 32'(instr));
    checkOutput({tag, ".pc"},    32'(pc_plus_8_decode_out),   32'(pc));
    checkOutput({tag, ".valid"}, 32'(valid_decode_out),       32'(valid));
  endtask

  initial begin
    // 1: reset
    rst = 1'b1;
    applyStimulus(22'h3ABCDE, 22'h000008, 0, 0, 0, 0, 0, 0, 0);
    tick(2);
    checkD("reset", 22'h0, 22'h0, 1'b0);
    checkOutput("reset.stall",  32'(stall_fetch_out),   0);
    checkOutput("reset.flush",  32'(flush_execute_out), 0);
    checkOutput("reset.bubble", 32'(bubble_count_out),  0);
    rst = 1'b0;
    tick(1);
    checkD("first_load", 22'h3ABCDE, 22'h000008, 1'b1);

    // 2: load-use on rn, then rm match, then register mismatch
    applyStimulus(22'h111111, 22'h000010, 0, 3, 5, 3, 1, 0, 0);
    checkOutput("lu.stall", 32'(stall_fetch_out),   1);
    checkOutput("lu.flush", 32'(flush_execute_out), 1);
    tick(1);
    checkD("lu_hold", 22'h3ABCDE, 22'h000008, 1'b1);
    checkOutput("lu.bubble", 32'(bubble_count_out), 1);
    applyStimulus(22'h111111, 22'h000010, 0, 2, 5, 5, 1, 0, 0);
    checkOutput("lu_rm.stall", 32'(stall_fetch_out), 1);
    applyStimulus(22'h111111, 22'h000010, 0, 2, 5, 7, 1, 0, 0);
    checkOutput("lu_miss.stall", 32'(stall_fetch_out),   0);
    checkOutput("lu_miss.flush", 32'(flush_execute_out), 0);
    applyStimulus(22'h111111, 22'h000010, 0, 3, 5, 3, 0, 0, 0);
    checkOutput("no_load.stall", 32'(stall_fetch_out), 0);
    tick(1);
    checkD("after_lu", 22'h111111, 22'h000010, 1'b1);

    // 3: taken branch
    applyStimulus(22'h222222, 22'h000018, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("br.flush", 32'(flush_execute_out), 1);
    checkOutput("br.stall", 32'(stall_fetch_out),   0);
    tick(1);
    checkD("br_bubble", NOP_INSTR, 22'h0, 1'b0);
    checkOutput("br.bubble", 32'(bubble_count_out), 2);
    applyStimulus(22'h333333, 22'h000020, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("post_br.flush", 32'(flush_execute_out), 0);
    tick(1);
    checkD("post_br", 22'h333333, 22'h000020, 1'b1);

    // 4: PC write: three NOPs in D/E/M, fourth from pc_src_w, then the target
    applyStimulus(22'h444444, 22'h000028, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("pcw.stall", 32'(stall_fetch_out),   0);
    checkOutput("pcw.flush", 32'(flush_execute_out), 0);
    tick(1);
    checkD("pcw_nop1", NOP_INSTR, 22'h0, 1'b0);
    applyStimulus(22'h444444, 22'h000028, 0, 0, 0, 0, 0, 0, 0);
    tick(1);
    checkD("pcw_nop2", NOP_INSTR, 22'h0, 1'b0);
    tick(1);
    checkD("pcw_nop3", NOP_INSTR, 22'h0, 1'b0);
    checkOutput("pcw.bubble3", 32'(bubble_count_out), 5);
    applyStimulus(22'h444444, 22'h000028, 0, 0, 0, 0, 0, 0, 1);
    tick(1);
    checkD("pcw_nop4", NOP_INSTR, 22'h0, 1'b0);
    applyStimulus(22'h155555, 22'h005558, 0, 0, 0, 0, 0, 0, 0);
    tick(1);
    checkD("pcw_target", 22'h155555, 22'h005558, 1'b1);
    checkOutput("pcw.bubble", 32'(bubble_count_out), 6);

    // 5: branch + pc_src_w + load-use together: branch case wins
    applyStimulus(22'h066666, 22'h000030, 0, 3, 0, 3, 1, 1, 1);
    checkOutput("simul.flush", 32'(flush_execute_out), 1);
    checkOutput("simul.stall", 32'(stall_fetch_out),   0);
    tick(1);
    checkD("simul", NOP_INSTR, 22'h0, 1'b0);
    checkOutput("simul.bubble", 32'(bubble_count_out), 7);

    // reset while stalled clears everything
    applyStimulus(22'h077777, 22'h000038, 0, 3, 0, 3, 0, 0, 0);
    tick(1);
    checkD("pre_rst", 22'h077777, 22'h000038, 1'b1);
    applyStimulus(22'h077777, 22'h000038, 0, 3, 0, 3, 1, 0, 0);
    checkOutput("pre_rst.stall", 32'(stall_fetch_out), 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    #1;
    checkD("mid_stall_rst", 22'h0, 22'h0, 1'b0);
    checkOutput("mid_stall_rst.stall",  32'(stall_fetch_out),  0);
    checkOutput("mid_stall_rst.bubble", 32'(bubble_count_out), 0);

    // 6: saturation with 20 forced bubbles on a 4-bit counter
    applyStimulus(22'h0, 22'h0, 0, 0, 0, 0, 0, 1, 0);
    tick(14);
    checkOutput("sat.14", 32'(bubble_count_out), 14);
    tick(1);
    checkOutput("sat.15", 32'(bubble_count_out), 15);
    tick(5);
    checkOutput("sat.20", 32'(bubble_count_out), 15);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    applyStimulus(22'h0ABCDE, 22'h000040, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("post_sat_rst.bubble", 32'(bubble_count_out),  0);
    checkOutput("post_sat_rst.flush",  32'(flush_execute_out), 0);
    checkOutput("post_sat_rst.stall",  32'(stall_fetch_out),   0);
    tick(1);
    checkD("post_sat_load", 22'h0ABCDE, 22'h000040, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
